// File: rtl/pcpi_muldiv_radix.sv
// pcpi_muldiv_radix: RV32M/RV64M multiply/divide co-processor on the PCPI port.
// Multiply is a registered product with optional retiming stages. Divide is an
// iterative restoring divider retiring DIV_BITS quotient bits per cycle, with
// early-out for divide-by-zero and signed overflow. A one-entry cache holds the
// last quotient/remainder pair, so a DIV+REM pair on the same operands iterates once.
module pcpi_muldiv_radix #(
    parameter int XLEN        = 32,
    parameter int DIV_BITS    = 2,
    parameter int MUL_LATENCY = 2,
    parameter bit CACHE_EN    = 1'b1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            valid,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            wr,
    output logic [XLEN-1:0] rd,
    output logic            busy,
    output logic            ready
);

    localparam int ITERS = XLEN / DIV_BITS;
    // ITERS is at least 8, so this width also covers the multiply latency count.
    localparam int CNT_W = $clog2(ITERS) + 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(ITERS - 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LATENCY - 1);
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV_PREP,
        DIV_ITER,
        DIV_FIX,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [XLEN-1:0]   prod_q [MUL_LATENCY];
    logic [XLEN-1:0]   prod_d [MUL_LATENCY];
    logic              cache_valid_q, cache_valid_d;
    logic [XLEN-1:0]   cache_a_q, cache_a_d;
    logic [XLEN-1:0]   cache_b_q, cache_b_d;
    logic              cache_signed_q, cache_signed_d;
    logic [XLEN-1:0]   cache_quo_q, cache_quo_d;
    logic [XLEN-1:0]   cache_rem_q, cache_rem_d;

    // Decode: only the M-extension opcode/funct7 pair is claimed.
    logic [2:0] funct3;
    logic       is_m;
    logic       accept;
    logic       unused_instr_bits;

    assign funct3            = instruction[14:12];
    assign is_m              = (instruction[6:0] == 7'b0110011) && (instruction[31:25] == 7'b0000001);
    assign accept            = (state_q == IDLE) && valid && is_m;
    assign unused_instr_bits = ^{instruction[24:15], instruction[11:7]};

    // Multiply product from the live operands; loaded into the first retiming stage at acceptance.
    logic                mul_a_signed, mul_b_signed;
    logic [2*XLEN-1:0]   mul_a_ext, mul_b_ext, mul_prod;
    logic [XLEN-1:0]     mul_res;

    always_comb begin
        mul_a_signed = (funct3[1:0] != 2'b11);   // MUL, MULH, MULHSU
        mul_b_signed = (funct3[1] == 1'b0);      // MUL, MULH
        mul_a_ext    = {{XLEN{mul_a_signed & rs1[XLEN-1]}}, rs1};
        mul_b_ext    = {{XLEN{mul_b_signed & rs2[XLEN-1]}}, rs2};
        mul_prod     = mul_a_ext * mul_b_ext;
        mul_res      = (funct3[1:0] == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
    end

    // Cache lookup keyed on operands and signedness (funct3[0] clear means signed).
    logic cache_hit;
    assign cache_hit = CACHE_EN && cache_valid_q && (cache_a_q == rs1) && (cache_b_q == rs2)
                       && (cache_signed_q == ~funct3[0]);

    // Divide preparation: magnitudes and early-out detection from the latched operands.
    logic            div_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b;

    always_comb begin
        div_signed = ~op_q[0];
        a_neg      = div_signed & a_q[XLEN-1];
        b_neg      = div_signed & b_q[XLEN-1];
        mag_a      = a_neg ? -a_q : a_q;
        mag_b      = b_neg ? -b_q : b_q;
        div_zero   = (b_q == '0);
        div_ovf    = div_signed && (a_q == MOST_NEG) && (b_q == '1);
    end

    // One divide cycle: DIV_BITS restoring radix-2 steps on {rem, dividend-shift}.
    logic [XLEN-1:0] step_rem, step_quo;
    logic [XLEN:0]   trial;

    always_comb begin
        step_rem = rem_q;
        step_quo = quo_q;
        trial    = '0;
        for (int i = 0; i < DIV_BITS; i++) begin
            trial    = {step_rem, step_quo[XLEN-1]};
            step_quo = {step_quo[XLEN-2:0], 1'b0};
            if (trial >= {1'b0, dvs_q}) begin
                trial       = trial - {1'b0, dvs_q};
                step_quo[0] = 1'b1;
            end
            step_rem = trial[XLEN-1:0];
        end
    end

    // Sign fix is combinational, so the corrected result is presented in DIV_FIX itself.
    logic [XLEN-1:0] fix_quo, fix_rem;

    always_comb begin
        fix_quo = neg_quo_q ? -quo_q : quo_q;
        fix_rem = neg_rem_q ? -rem_q : rem_q;
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        a_d            = a_q;
        b_d            = b_q;
        quo_d          = quo_q;
        rem_d          = rem_q;
        dvs_d          = dvs_q;
        neg_quo_d      = neg_quo_q;
        neg_rem_d      = neg_rem_q;
        cnt_d          = cnt_q;
        result_d       = result_q;
        cache_valid_d  = cache_valid_q;
        cache_a_d      = cache_a_q;
        cache_b_d      = cache_b_q;
        cache_signed_d = cache_signed_q;
        cache_quo_d    = cache_quo_q;
        cache_rem_d    = cache_rem_q;
        prod_d[0]      = prod_q[0];
        for (int i = 1; i < MUL_LATENCY; i++) begin
            prod_d[i] = prod_q[i-1];
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d = funct3;
                    a_d  = rs1;
                    b_d  = rs2;
                    if (!funct3[2]) begin
                        prod_d[0] = mul_res;
                        cnt_d     = CNT_W'(1);
                        state_d   = (MUL_LATENCY == 1) ? DONE : MUL;
                    end else if (cache_hit) begin
                        result_d = funct3[1] ? cache_rem_q : cache_quo_q;
                        state_d  = DONE;
                    end else begin
                        state_d = DIV_PREP;
                    end
                end
            end
            MUL: begin
                if (!valid) begin
                    state_d = IDLE;
                end else if (cnt_q == MUL_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DIV_PREP: begin
                if (!valid) begin
                    state_d = IDLE;
                end else if (div_zero || div_ovf) begin
                    cache_quo_d = div_zero ? '1 : a_q;
                    cache_rem_d = div_zero ? a_q : '0;
                    result_d    = op_q[1] ? cache_rem_d : cache_quo_d;
                    if (CACHE_EN) begin
                        cache_valid_d  = 1'b1;
                        cache_a_d      = a_q;
                        cache_b_d      = b_q;
                        cache_signed_d = div_signed;
                    end
                    state_d = DONE;
                end else begin
                    quo_d     = mag_a;
                    rem_d     = '0;
                    dvs_d     = mag_b;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    cnt_d     = '0;
                    state_d   = DIV_ITER;
                end
            end
            DIV_ITER: begin
                if (!valid) begin
                    state_d = IDLE;
                end else begin
                    quo_d = step_quo;
                    rem_d = step_rem;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == DIV_LAST) begin
                        state_d = DIV_FIX;
                    end
                end
            end
            DIV_FIX: begin
                if (CACHE_EN) begin
                    cache_valid_d  = 1'b1;
                    cache_a_d      = a_q;
                    cache_b_d      = b_q;
                    cache_signed_d = ~op_q[0];
                    cache_quo_d    = fix_quo;
                    cache_rem_d    = fix_rem;
                end
                state_d = IDLE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= IDLE;
            op_q           <= '0;
            a_q            <= '0;
            b_q            <= '0;
            quo_q          <= '0;
            rem_q          <= '0;
            dvs_q          <= '0;
            neg_quo_q      <= 1'b0;
            neg_rem_q      <= 1'b0;
            cnt_q          <= '0;
            result_q       <= '0;
            cache_valid_q  <= 1'b0;
            cache_a_q      <= '0;
            cache_b_q      <= '0;
            cache_signed_q <= 1'b0;
            cache_quo_q    <= '0;
            cache_rem_q    <= '0;
            for (int i = 0; i < MUL_LATENCY; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            a_q            <= a_d;
            b_q            <= b_d;
            quo_q          <= quo_d;
            rem_q          <= rem_d;
            dvs_q          <= dvs_d;
            neg_quo_q      <= neg_quo_d;
            neg_rem_q      <= neg_rem_d;
            cnt_q          <= cnt_d;
            result_q       <= result_d;
            cache_valid_q  <= cache_valid_d;
            cache_a_q      <= cache_a_d;
            cache_b_q      <= cache_b_d;
            cache_signed_q <= cache_signed_d;
            cache_quo_q    <= cache_quo_d;
            cache_rem_q    <= cache_rem_d;
            for (int i = 0; i < MUL_LATENCY; i++) begin
                prod_q[i] <= prod_d[i];
            end
        end
    end

    // Outputs: result is driven only in the single completion cycle, zero otherwise.
    always_comb begin
        busy  = (state_q != IDLE);
        ready = (state_q == DONE) || (state_q == DIV_FIX);
        wr    = ready;
        rd    = '0;
        if (state_q == DONE) begin
            rd = op_q[2] ? result_q : prod_q[MUL_LATENCY-1];
        end else if (state_q == DIV_FIX) begin
            rd = op_q[1] ? fix_rem : fix_quo;
        end
    end

endmodule

// File: doc/pcpi_muldiv_radix.md
Name: pcpi_muldiv_radix

Overview:
- Parametrised next-generation RV32M/RV64M multiply/divide co-processor on the PCPI port.
- Executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Multiply uses a configurable-latency pipelined product; divide uses a configurable-radix iterative restoring divider.
- Adds early-out for divide-by-zero and signed overflow.
- Adds a one-entry DIV/REM result cache so a paired DIV+REM on the same operands costs one iteration sequence.

Parameters:
- XLEN, 32, operand and result width (32 or 64).
- DIV_BITS, 2, quotient bits retired per divide cycle (1, 2 or 4); must divide XLEN.
- MUL_LATENCY, 2, cycles from acceptance to multiply result (1 to 4); extra cycles are retiming registers on the product.
- CACHE_EN, 1, enables the DIV/REM result cache.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- valid  in  1  PCPI request valid; held by host until ready
- instruction  in  32  instruction word
- rs1  in  XLEN  operand 1
- rs2  in  XLEN  operand 2
- wr  out  1  write-back strobe
- rd  out  XLEN  result
- busy  out  1  unit has claimed the instruction
- ready  out  1  result valid this cycle

Behaviour:
- Reset: one clock; reset is asynchronous, active-low (clk, resetn).
  - While resetn is low: state=IDLE, wr=0, ready=0, busy=0, rd=0, cache invalid.
  - Asserting reset mid-operation aborts the operation with no ready.
- Decode: an instruction is claimed only if opcode=0110011 and funct7=0000001. funct3 selects the operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU. Any other instruction is ignored: no busy, no ready, no state change.
- Acceptance: cycle 0 is the cycle in which the unit is in IDLE, valid=1 and the instruction decodes as M. rs1, rs2 and funct3 are latched at that edge.
- States: IDLE, MUL, DIV_PREP, DIV_ITER, DIV_FIX, DONE.
- Latency N (ready asserted in cycle N):
  - Cache hit: N=1.
  - Divide-by-zero or signed overflow: N=2.
  - Multiply: N=MUL_LATENCY.
  - Normal divide: N=XLEN/DIV_BITS+2 (one prep/abs cycle, XLEN/DIV_BITS iterations, one sign-fix cycle).
- busy is high in cycles 1..N inclusive. ready and wr are high for exactly one cycle (cycle N), with rd valid. rd is 0 in every other cycle.
- The host drops valid in the cycle after ready. The unit is in IDLE in that cycle and may accept a new request in the following cycle.
- Abort: if valid falls while busy and before ready, the unit returns to IDLE next cycle with no ready/wr. The cache is not updated.
- Multiply:
  - Signed operands are sign-extended to XLEN+1 bits; MULHU zero-extends both; MULHSU sign-extends rs1 and zero-extends rs2.
  - The 2*XLEN product's low half is returned for MUL, high half for the MULH variants.
- Divide:
  - Operates on magnitudes; quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1); applied in DIV_FIX.
  - Divisor 0: quotient = all ones, remainder = rs1.
  - Signed DIV/REM with rs1 = most-negative and rs2 = -1: quotient = rs1, remainder = 0.
- Cache:
  - On completion of any DIV-class operation (including early-outs), store rs1, rs2, signedness, quotient and remainder.
  - A later DIV-class request with identical rs1, rs2 and signedness hits and returns the quotient or remainder per funct3.
  - Multiplies do not touch the cache.
  - CACHE_EN=0 disables hits entirely.

Test Plan:
- MULH 0x80000000*0x80000000 -> rd=0x40000000. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> rd=0xFFFFFFFF. MUL 7*(-3) -> rd=0xFFFFFFEB. All three: ready exactly in cycle MUL_LATENCY, busy high cycles 1..MUL_LATENCY.
- XLEN=32, DIV_BITS=2: DIV -7/2 -> rd=0xFFFFFFFD with ready in cycle 18. The following REM -7/2 is a cache hit -> rd=0xFFFFFFFF with ready in cycle 1.
- DIVU 5/0 -> rd=0xFFFFFFFF and REMU 5/0 -> rd=5. DIV 0x80000000/0xFFFFFFFF -> rd=0x80000000 and REM -> 0. Each ready in cycle 2 when not a cache hit.
- Non-M instruction (funct7=0000000, opcode 0110011) with valid held high for 40 cycles -> busy, ready and wr stay 0 throughout.
- resetn low in cycle 5 of a DIVU 100/7, then the same DIVU is reissued -> no ready before the reset; the reissued op misses the cache, returns rd=14, and takes full latency.
- valid dropped in cycle 4 of a divide -> no ready or wr. The next accepted REM on the same operands misses the cache and returns the correct remainder.
